fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder in the RISC-V MMC CPU.
- Holds the PC and issues one word-aligned request at a time to instruction memory over a valid/ready request channel with a valid-only response.
- Presents each fetched instruction and its PC to the decoder under a valid/ready handshake.
- Accepts PC redirects (taken branch, jal, jalr) from the execute/PC-select logic and squashes in-flight or held wrong-path fetches.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// Module  : riscv_pkg
// Brief   : Shared types and constants for the RISC-V MMC CPU front end.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Decoder PC-select encoding; the redirect source is one of the non-PLUS4 cases.
  typedef enum logic [1:0] {
    PCS_PLUS4  = 2'd0,
    PCS_BRANCH = 2'd1,
    PCS_JAL    = 2'd2,
    PCS_JALR   = 2'd3
  } pcs_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : Single-outstanding instruction fetch stage with PC redirect/squash.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) state_d = REQ;
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // A redirect overrides everything above: any data landing this cycle is wrong-path.
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      unique case (state_q)
        REQ:     state_d = imem_req_ready ? DROP : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC_ALIGNED;
      instr_q    <= XLEN'(NOP_INSTR);
      instr_pc_q <= RESET_PC_ALIGNED;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req_valid = rst_n && (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;

  // Memory must only respond while a request is outstanding.
  a_rsp_only_when_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state_q == WAIT || state_q == DROP)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Brief   : Directed self-checking bench for fetch_unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        rst_n2;
  logic        imem_req_valid2;
  logic        imem_req_ready2;
  logic [31:0] imem_req_addr2;
  logic        imem_rsp_valid2;
  logic [31:0] imem_rsp_data2;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n2),
    .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready2),
    .imem_req_addr(imem_req_addr2), .imem_rsp_valid(imem_rsp_valid2),
    .imem_rsp_data(imem_rsp_data2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .instr(instr2), .instr_pc(instr_pc2),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request/response pair on the main DUT starting from REQ.
  task automatic fetch_one(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_release_req: got valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_fetch_backpressure();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wait_req_valid: got %b expected 0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL first_instr: got v=%b instr=%h pc=%h expected v=1 instr=00500093 pc=00000000", instr_valid, instr, instr_pc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d]: got v=%b instr=%h pc=%h req=%b expected v=1 instr=00500093 pc=00000000 req=0", i, instr_valid, instr, instr_pc, imem_req_valid);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      errors++; $display("FAIL next_req: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000004", instr_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got req=%b v=%b expected req=0 v=0", imem_req_valid, instr_valid);
    end
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++; $display("FAIL drop_done: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000100", instr_valid, imem_req_valid, imem_req_addr);
    end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL drop_instr_held: got %h expected 00500093", instr); end
  endtask

  task automatic test_redirect_hold();
    fetch_one(32'h00A0_0113);
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h100) begin
      errors++; $display("FAIL post_drop_fetch: got v=%b instr=%h pc=%h expected v=1 instr=00a00113 pc=00000100", instr_valid, instr, instr_pc);
    end
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      errors++; $display("FAIL hold_redirect: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000040", instr_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++; $display("FAIL req_redirect_1: got req=%b addr=%h expected req=1 addr=00000200", imem_req_valid, imem_req_addr);
    end
    redirect_pc = 32'h0000_0302;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
      errors++; $display("FAIL req_redirect_2: got req=%b addr=%h expected req=1 addr=00000300", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_corner();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL req_accept_redirect: got req=%b expected 0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h80 || imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL drop_to_req: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000080", instr_valid, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    step();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500 || instr !== 32'h00A0_0113) begin
      errors++; $display("FAIL wait_rsp_redirect: got v=%b req=%b addr=%h instr=%h expected v=0 req=1 addr=00000500 instr=00a00113", instr_valid, imem_req_valid, imem_req_addr, instr);
    end
  endtask

  task automatic test_wrap();
    rst_n2 = 1'b0;
    step();
    rst_n2 = 1'b1;
    #1;
    checks++; if (imem_req_valid2 !== 1'b1 || imem_req_addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_reset_addr: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req_valid2, imem_req_addr2);
    end
    imem_req_ready2 = 1'b1;
    step();
    imem_req_ready2 = 1'b0;
    imem_rsp_valid2 = 1'b1;
    imem_rsp_data2  = 32'h0010_0073;
    step();
    imem_rsp_valid2 = 1'b0;
    checks++; if (instr_valid2 !== 1'b1 || instr2 !== 32'h0010_0073 || instr_pc2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_instr: got v=%b instr=%h pc=%h expected v=1 instr=00100073 pc=fffffffc", instr_valid2, instr2, instr_pc2);
    end
    instr_ready2 = 1'b1;
    step();
    instr_ready2 = 1'b0;
    checks++; if (imem_req_valid2 !== 1'b1 || imem_req_addr2 !== 32'h0) begin
      errors++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected req=1 addr=00000000", imem_req_valid2, imem_req_addr2);
    end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_0BAD;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_req: got %b expected 0", imem_req_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL mid_reset_release: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000000", instr_valid, imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req_addr !== 32'h0) begin
        errors++; $display("FAIL mid_reset_stale[%0d]: got v=%b instr=%h addr=%h expected v=0 instr=00000013 addr=00000000", i, instr_valid, instr, imem_req_addr);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    rst_n2          = 1'b0;
    imem_req_ready2 = 1'b0;
    imem_rsp_valid2 = 1'b0;
    imem_rsp_data2  = 32'h0;
    instr_ready2    = 1'b0;

    test_reset();
    test_fetch_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_back_to_back();
    test_redirect_corner();
    test_wrap();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
